mpu_regfile_arbiter: RTL

MPU_REGFILE_ARBITER -- requirements
Module: mpu_regfile_arbiter

---
 rtl/mpu_regfile_arbiter_pkg.sv | 20 ++
 rtl/mpu_regfile_arbiter_rr_picker.sv | 37 +++
 rtl/mpu_regfile_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mpu_regfile_arbiter_pkg.sv
// ============================================================================
// Packages global_defs and mpu_data_types: shared constants and the arbiter
// state encoding.  Revision: 1.0
// ============================================================================
`default_nettype none

package global_defs;
  localparam int ARB_NUM_REQ        = 4;
  localparam int ARB_TIMEOUT_CYCLES = 64;
endpackage : global_defs

package mpu_data_types;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;
endpackage : mpu_data_types

`default_nettype wire

// File: rtl/mpu_regfile_arbiter_rr_picker.sv
// ============================================================================
// Module mpu_rr_picker: combinational round-robin winner search starting at
// a given pointer and wrapping upward.  Revision: 1.0
// ============================================================================
`default_nettype none

module mpu_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] winner_onehot,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  int cand;

  always_comb begin
    winner_onehot = '0;
    winner_idx    = '0;
    valid         = 1'b0;
    cand          = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(start) + i) % NUM_REQ;
      if (!valid && req[cand]) begin
        valid               = 1'b1;
        winner_onehot[cand] = 1'b1;
        winner_idx          = IDX_W'(cand);
      end
    end
  end

endmodule : mpu_rr_picker

`default_nettype wire

// File: rtl/mpu_regfile_arbiter.sv
// ============================================================================
// Module mpu_regfile_arbiter: round-robin register-file arbiter with a
// one-cycle release turnaround.  Optional tenure limit: MPU_ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mpu_regfile_arbiter
  import global_defs::*;
  import mpu_data_types::*;
#(
  parameter int NUM_REQ        = ARB_NUM_REQ,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_in,
  output logic [NUM_REQ-1:0]         grant_out,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_out,
  output logic                       busy_out,
  output logic                       timeout_err_out
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   id_q, id_d;
  logic [IDX_W-1:0]   last_winner_q, last_winner_d;
  logic [IDX_W-1:0]   start_ptr;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               tenure_expired;

  // Search begins just past the previous winner so a re-raised request waits its turn.
  assign start_ptr = (last_winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : last_winner_q + IDX_W'(1);

  mpu_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req           (req_in),
    .start         (start_ptr),
    .winner_onehot (pick_onehot),
    .winner_idx    (pick_idx),
    .valid         (pick_valid)
  );

`ifdef MPU_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tenure_cnt_q;
  logic             timeout_err_q;

  assign tenure_expired = (state_q == GRANT) && (tenure_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tenure_cnt_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == GRANT) tenure_cnt_q <= tenure_cnt_q + CNT_W'(1);
      else                  tenure_cnt_q <= '0;
      if (tenure_expired)   timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err_out = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign tenure_expired     = 1'b0;
  assign timeout_err_out    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    id_d          = id_q;
    last_winner_d = last_winner_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d       = GRANT;
          grant_d       = pick_onehot;
          id_d          = pick_idx;
          last_winner_d = pick_idx;
        end
      end
      GRANT: begin
        if (!req_in[id_q] || tenure_expired) begin
          state_d = RELEASE;
          grant_d = '0;
          id_d    = '0;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      id_q          <= '0;
      last_winner_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      id_q          <= id_d;
      last_winner_q <= last_winner_d;
    end
  end

  assign grant_out    = grant_q;
  assign grant_id_out = id_q;
  assign busy_out     = (state_q == GRANT);

endmodule : mpu_regfile_arbiter

`default_nettype wire
